// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS32 pipeline.
// Holds the EX/MEM register, performs word loads and stores over a valid/ready
// data-memory interface, resolves branches, drives the MEM/WB register and
// provides the MEM-stage forwarding path.
module mem_stage #(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    // EX-stage outputs
    input  logic [31:0] alu_out_e,
    input  logic [31:0] write_data_e,
    input  logic [4:0]  write_reg_e,
    input  logic        reg_write_e,
    input  logic        mem_to_reg_e,
    input  logic        mem_write_e,
    input  logic        branch_e,
    input  logic        zero_e,
    input  logic [31:0] pc_branch_e,
    // data memory
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_resp_rdata,
    // pipeline control
    output logic        stall_m,
    output logic        pc_src_m,
    output logic [31:0] pc_branch_m,
    // MEM-stage forwarding
    output logic        fwd_valid_m,
    output logic [4:0]  fwd_reg_m,
    output logic [31:0] fwd_data_m,
    // MEM/WB register
    output logic        reg_write_w,
    output logic [4:0]  write_reg_w,
    output logic [31:0] result_w,
    output logic        misaligned_w,
    output logic        bus_err_w
);

    // Counter must be able to hold RESP_TIMEOUT itself.
    localparam int CNT_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // EX/MEM register
    logic [31:0] alu_out_q;
    logic [31:0] write_data_q;
    logic [4:0]  write_reg_q;
    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic        mem_write_q;
    logic        branch_q;
    logic        zero_q;
    logic [31:0] pc_branch_q;

    // MEM/WB register
    logic        reg_write_w_q;
    logic [4:0]  write_reg_w_q;
    logic [31:0] result_w_q;
    logic        misaligned_w_q;
    logic        bus_err_w_q;

    logic mem_op_m;
    logic mis_m;
    logic timeout_m;
    logic in_mem_aligned;

    assign mem_op_m       = mem_to_reg_q | mem_write_q;
    assign mis_m          = mem_op_m & (alu_out_q[1:0] != 2'b00);
    assign in_mem_aligned = (mem_to_reg_e | mem_write_e) & (alu_out_e[1:0] == 2'b00);

    // Abort on the RESP_TIMEOUT-th WAIT cycle without a response; a response
    // arriving in that same cycle still wins.
    assign timeout_m = (state_q == ST_WAIT) & ~dmem_resp_valid & (cnt_q == CNT_LAST);

    assign stall_m = ((state_q == ST_REQ) & ~(dmem_req_ready & mem_write_q))
                   | ((state_q == ST_WAIT) & ~dmem_resp_valid & ~timeout_m);

    // Request fields come straight from the EX/MEM register, so they stay
    // stable for as long as the request is outstanding.
    assign dmem_req_valid = (state_q == ST_REQ);
    assign dmem_req_we    = mem_write_q;
    assign dmem_req_addr  = {alu_out_q[31:2], 2'b00};
    assign dmem_req_wdata = write_data_q;

    assign pc_src_m    = branch_q & zero_q;
    assign pc_branch_m = pc_branch_q;

    // Load data is not available in MEM, so loads are never forwarded from here.
    assign fwd_valid_m = reg_write_q & ~mem_to_reg_q & (write_reg_q != 5'd0);
    assign fwd_reg_m   = write_reg_q;
    assign fwd_data_m  = alu_out_q;

    assign reg_write_w  = reg_write_w_q;
    assign write_reg_w  = write_reg_w_q;
    assign result_w     = result_w_q;
    assign misaligned_w = misaligned_w_q;
    assign bus_err_w    = bus_err_w_q;

    // EX/MEM register: capture the EX outputs unless MEM is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q    <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            zero_q       <= 1'b0;
            pc_branch_q  <= '0;
        end else if (!stall_m) begin
            alu_out_q    <= alu_out_e;
            write_data_q <= write_data_e;
            write_reg_q  <= write_reg_e;
            reg_write_q  <= reg_write_e;
            mem_to_reg_q <= mem_to_reg_e;
            mem_write_q  <= mem_write_e;
            branch_q     <= branch_e;
            zero_q       <= zero_e;
            pc_branch_q  <= pc_branch_e;
        end
    end

    // Next-state logic: a completing (non-stalled) cycle always picks the state
    // for the instruction being loaded into EX/MEM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_REQ: begin
                if (dmem_req_ready && !mem_write_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!stall_m) begin
            state_d = in_mem_aligned ? ST_REQ : ST_IDLE;
        end
    end

    // State register and response timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB register: loads every cycle, a bubble while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_w_q  <= 1'b0;
            write_reg_w_q  <= '0;
            result_w_q     <= '0;
            misaligned_w_q <= 1'b0;
            bus_err_w_q    <= 1'b0;
        end else begin
            reg_write_w_q  <= ~stall_m & reg_write_q & ~mis_m & ~timeout_m;
            write_reg_w_q  <= write_reg_q;
            result_w_q     <= mem_to_reg_q ? dmem_resp_rdata : alu_out_q;
            misaligned_w_q <= ~stall_m & mis_m;
            bus_err_w_q    <= timeout_m;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU op, store, load, branch, misaligned
// access, load timeout and reset during a pending load.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu_out_e;
    logic [31:0] write_data_e;
    logic [4:0]  write_reg_e;
    logic        reg_write_e;
    logic        mem_to_reg_e;
    logic        mem_write_e;
    logic        branch_e;
    logic        zero_e;
    logic [31:0] pc_branch_e;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        stall_m;
    logic        pc_src_m;
    logic [31:0] pc_branch_m;
    logic        fwd_valid_m;
    logic [4:0]  fwd_reg_m;
    logic [31:0] fwd_data_m;
    logic        reg_write_w;
    logic [4:0]  write_reg_w;
    logic [31:0] result_w;
    logic        misaligned_w;
    logic        bus_err_w;

    int checks   = 0;
    int failures = 0;

    mem_stage #(.RESP_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_out_e       (alu_out_e),
        .write_data_e    (write_data_e),
        .write_reg_e     (write_reg_e),
        .reg_write_e     (reg_write_e),
        .mem_to_reg_e    (mem_to_reg_e),
        .mem_write_e     (mem_write_e),
        .branch_e        (branch_e),
        .zero_e          (zero_e),
        .pc_branch_e     (pc_branch_e),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .stall_m         (stall_m),
        .pc_src_m        (pc_src_m),
        .pc_branch_m     (pc_branch_m),
        .fwd_valid_m     (fwd_valid_m),
        .fwd_reg_m       (fwd_reg_m),
        .fwd_data_m      (fwd_data_m),
        .reg_write_w     (reg_write_w),
        .write_reg_w     (write_reg_w),
        .result_w        (result_w),
        .misaligned_w    (misaligned_w),
        .bus_err_w       (bus_err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, observed);
        end
    endtask

    // Advance one clock; inputs and outputs are handled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_bubble();
        alu_out_e    = 32'h0;
        write_data_e = 32'h0;
        write_reg_e  = 5'd0;
        reg_write_e  = 1'b0;
        mem_to_reg_e = 1'b0;
        mem_write_e  = 1'b0;
        branch_e     = 1'b0;
        zero_e       = 1'b0;
        pc_branch_e  = 32'h0;
    endtask

    task automatic ex_load(input logic [31:0] addr, input logic [4:0] rd);
        ex_bubble();
        alu_out_e    = addr;
        write_reg_e  = rd;
        reg_write_e  = 1'b1;
        mem_to_reg_e = 1'b1;
    endtask

    initial begin
        rst             = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
        ex_bubble();
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_stall", {31'd0, stall_m}, 32'd0);
        check("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        check("rst_reg_write_w", {31'd0, reg_write_w}, 32'd0);
        check("rst_result_w", result_w, 32'h0);

        // 1. ALU op r5 <= 0x1234
        alu_out_e   = 32'h1234;
        write_reg_e = 5'd5;
        reg_write_e = 1'b1;
        step();
        ex_bubble();
        check("alu_fwd_valid", {31'd0, fwd_valid_m}, 32'd1);
        check("alu_fwd_reg", {27'd0, fwd_reg_m}, 32'd5);
        check("alu_fwd_data", fwd_data_m, 32'h1234);
        check("alu_stall", {31'd0, stall_m}, 32'd0);
        step();
        check("alu_reg_write_w", {31'd0, reg_write_w}, 32'd1);
        check("alu_write_reg_w", {27'd0, write_reg_w}, 32'd5);
        check("alu_result_w", result_w, 32'h1234);
        check("alu_fwd_after", {31'd0, fwd_valid_m}, 32'd0);

        // 2. Store 0xDEADBEEF to 0x100, memory ready at once
        dmem_req_ready = 1'b1;
        alu_out_e      = 32'h100;
        write_data_e   = 32'hDEADBEEF;
        mem_write_e    = 1'b1;
        step();
        ex_bubble();
        check("st_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        check("st_req_we", {31'd0, dmem_req_we}, 32'd1);
        check("st_req_addr", dmem_req_addr, 32'h100);
        check("st_req_wdata", dmem_req_wdata, 32'hDEADBEEF);
        check("st_stall", {31'd0, stall_m}, 32'd0);
        step();
        check("st_req_done", {31'd0, dmem_req_valid}, 32'd0);
        check("st_reg_write_w", {31'd0, reg_write_w}, 32'd0);

        // 3. Load r7 from 0x200: ready after 2 cycles, response 3 cycles later
        dmem_req_ready = 1'b0;
        ex_load(32'h200, 5'd7);
        step();
        ex_bubble();
        check("ld_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        check("ld_req_we", {31'd0, dmem_req_we}, 32'd0);
        check("ld_req_addr", dmem_req_addr, 32'h200);
        check("ld_stall_req", {31'd0, stall_m}, 32'd1);
        step();
        dmem_req_ready = 1'b1;
        check("ld_stall_ready", {31'd0, stall_m}, 32'd1);
        step();
        dmem_req_ready = 1'b0;
        check("ld_wait_valid", {31'd0, dmem_req_valid}, 32'd0);
        check("ld_stall_wait", {31'd0, stall_m}, 32'd1);
        check("ld_wb_bubble", {31'd0, reg_write_w}, 32'd0);
        step();
        step();
        check("ld_stall_wait2", {31'd0, stall_m}, 32'd1);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hCAFEF00D;
        #1;
        check("ld_stall_resp", {31'd0, stall_m}, 32'd0);
        step();
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
        check("ld_reg_write_w", {31'd0, reg_write_w}, 32'd1);
        check("ld_write_reg_w", {27'd0, write_reg_w}, 32'd7);
        check("ld_result_w", result_w, 32'hCAFEF00D);
        step();
        check("ld_single_write", {31'd0, reg_write_w}, 32'd0);

        // 4. Branch taken then not taken
        branch_e    = 1'b1;
        zero_e      = 1'b1;
        pc_branch_e = 32'h40;
        step();
        ex_bubble();
        check("br_pc_src", {31'd0, pc_src_m}, 32'd1);
        check("br_pc_branch", pc_branch_m, 32'h40);
        check("br_stall", {31'd0, stall_m}, 32'd0);
        step();
        check("br_pc_src_after", {31'd0, pc_src_m}, 32'd0);
        branch_e    = 1'b1;
        zero_e      = 1'b0;
        pc_branch_e = 32'h40;
        step();
        ex_bubble();
        check("brnt_pc_src", {31'd0, pc_src_m}, 32'd0);

        // 5. Misaligned load from 0x102
        ex_load(32'h102, 5'd9);
        step();
        ex_bubble();
        check("mis_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        check("mis_stall", {31'd0, stall_m}, 32'd0);
        step();
        check("mis_pulse", {31'd0, misaligned_w}, 32'd1);
        check("mis_reg_write_w", {31'd0, reg_write_w}, 32'd0);
        step();
        check("mis_pulse_end", {31'd0, misaligned_w}, 32'd0);

        // 6a. Load with no response: abort after 4 WAIT cycles
        dmem_req_ready = 1'b1;
        ex_load(32'h300, 5'd3);
        step();
        ex_bubble();
        check("to_stall_req", {31'd0, stall_m}, 32'd1);
        step();
        check("to_wait0_stall", {31'd0, stall_m}, 32'd1);
        step();
        step();
        check("to_wait2_stall", {31'd0, stall_m}, 32'd1);
        check("to_wait2_err", {31'd0, bus_err_w}, 32'd0);
        step();
        check("to_wait3_release", {31'd0, stall_m}, 32'd0);
        step();
        check("to_bus_err", {31'd0, bus_err_w}, 32'd1);
        check("to_reg_write_w", {31'd0, reg_write_w}, 32'd0);
        check("to_stall_after", {31'd0, stall_m}, 32'd0);
        step();
        check("to_bus_err_end", {31'd0, bus_err_w}, 32'd0);

        // 6b. Reset while waiting; a late response must be ignored
        ex_load(32'h400, 5'd4);
        step();
        ex_bubble();
        step();
        check("rw_stall_wait", {31'd0, stall_m}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rw_stall", {31'd0, stall_m}, 32'd0);
        check("rw_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        check("rw_req_addr", dmem_req_addr, 32'h0);
        check("rw_reg_write_w", {31'd0, reg_write_w}, 32'd0);
        check("rw_result_w", result_w, 32'h0);
        check("rw_bus_err", {31'd0, bus_err_w}, 32'd0);
        check("rw_fwd_valid", {31'd0, fwd_valid_m}, 32'd0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h55AA55AA;
        #1;
        check("late_stall", {31'd0, stall_m}, 32'd0);
        step();
        dmem_resp_valid = 1'b0;
        check("late_reg_write_w", {31'd0, reg_write_w}, 32'd0);
        check("late_result_w", result_w, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
